// File: rtl/mux_sel_gen.sv
// Select-sequence generator for the Versat two-input mux unit: optional run-in
// of zeros, then a repeated period of len0 zeros followed by len1 ones.
module mux_sel_gen #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             running,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] len0,
    input  logic [CNT_W-1:0] len1,
    input  logic [CNT_W-1:0] iter,
    output logic             sel,
    output logic             done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        PH0   = 2'd2,
        PH1   = 2'd3
    } state_t;

    typedef struct packed {
        state_t           state;
        logic [CNT_W-1:0] cnt;
        logic             sel;
        logic             done;
    } entry_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    // First step of a period; zero-length phases are skipped so no bubble cycle appears.
    function automatic entry_t period_entry(input logic [CNT_W-1:0] it,
                                            input logic [CNT_W-1:0] l0,
                                            input logic [CNT_W-1:0] l1);
        entry_t e;
        if ((it == CNT_ZERO) || ((l0 == CNT_ZERO) && (l1 == CNT_ZERO))) begin
            e.state = IDLE;
            e.cnt   = CNT_ZERO;
            e.sel   = 1'b0;
            e.done  = 1'b1;
        end else if (l0 != CNT_ZERO) begin
            e.state = PH0;
            e.cnt   = l0;
            e.sel   = 1'b0;
            e.done  = 1'b0;
        end else begin
            e.state = PH1;
            e.cnt   = l1;
            e.sel   = 1'b1;
            e.done  = 1'b0;
        end
        return e;
    endfunction

    state_t           state_q, state_d;
    logic             sel_q, sel_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] phase_cnt_q, phase_cnt_d;
    logic [CNT_W-1:0] iter_cnt_q, iter_cnt_d;
    logic [CNT_W-1:0] len0_q, len0_d;
    logic [CNT_W-1:0] len1_q, len1_d;
    entry_t           start_s;
    entry_t           entry_s;

    // Next-state logic: run restarts from raw inputs, otherwise advance only while running.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        done_d      = done_q;
        phase_cnt_d = phase_cnt_q;
        iter_cnt_d  = iter_cnt_q;
        len0_d      = len0_q;
        len1_d      = len1_q;
        start_s     = period_entry(iter, len0, len1);
        entry_s     = period_entry(iter_cnt_q, len0_q, len1_q);

        if (run) begin
            len0_d     = len0;
            len1_d     = len1;
            iter_cnt_d = iter;
            if (delay != CNT_ZERO) begin
                state_d     = DELAY;
                phase_cnt_d = delay;
                sel_d       = 1'b0;
                done_d      = 1'b0;
            end else begin
                state_d     = start_s.state;
                phase_cnt_d = start_s.cnt;
                sel_d       = start_s.sel;
                done_d      = start_s.done;
            end
        end else if (running) begin
            case (state_q)
                IDLE: begin
                    state_d = IDLE;
                end
                DELAY: begin
                    if (phase_cnt_q != CNT_ONE) begin
                        phase_cnt_d = phase_cnt_q - CNT_ONE;
                    end else begin
                        state_d     = entry_s.state;
                        phase_cnt_d = entry_s.cnt;
                        sel_d       = entry_s.sel;
                        done_d      = entry_s.done;
                    end
                end
                PH0: begin
                    if (phase_cnt_q != CNT_ONE) begin
                        phase_cnt_d = phase_cnt_q - CNT_ONE;
                    end else if (len1_q != CNT_ZERO) begin
                        state_d     = PH1;
                        phase_cnt_d = len1_q;
                        sel_d       = 1'b1;
                    end else if (iter_cnt_q == CNT_ONE) begin
                        state_d     = IDLE;
                        phase_cnt_d = CNT_ZERO;
                        iter_cnt_d  = CNT_ZERO;
                        sel_d       = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        // Period of only zeros: this PH0 end is the iteration boundary.
                        iter_cnt_d  = iter_cnt_q - CNT_ONE;
                        state_d     = entry_s.state;
                        phase_cnt_d = entry_s.cnt;
                        sel_d       = entry_s.sel;
                        done_d      = entry_s.done;
                    end
                end
                PH1: begin
                    if (phase_cnt_q != CNT_ONE) begin
                        phase_cnt_d = phase_cnt_q - CNT_ONE;
                    end else if (iter_cnt_q == CNT_ONE) begin
                        state_d     = IDLE;
                        phase_cnt_d = CNT_ZERO;
                        iter_cnt_d  = CNT_ZERO;
                        sel_d       = 1'b0;
                        done_d      = 1'b1;
                    end else begin
                        iter_cnt_d  = iter_cnt_q - CNT_ONE;
                        state_d     = entry_s.state;
                        phase_cnt_d = entry_s.cnt;
                        sel_d       = entry_s.sel;
                        done_d      = entry_s.done;
                    end
                end
                default: begin
                    state_d     = IDLE;
                    phase_cnt_d = CNT_ZERO;
                    iter_cnt_d  = CNT_ZERO;
                    sel_d       = 1'b0;
                    done_d      = 1'b1;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // State, counter and output registers; reset aborts any sequence.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= 1'b0;
            done_q      <= 1'b1;
            phase_cnt_q <= CNT_ZERO;
            iter_cnt_q  <= CNT_ZERO;
            len0_q      <= CNT_ZERO;
            len1_q      <= CNT_ZERO;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            done_q      <= done_d;
            phase_cnt_q <= phase_cnt_d;
            iter_cnt_q  <= iter_cnt_d;
            len0_q      <= len0_d;
            len1_q      <= len1_d;
        end
    end

    assign sel  = sel_q;
    assign done = done_q;

endmodule
